turn_sequencer: RTL and testbench

Parametrised turn sequencer for the board-game controller, generalising the fixed 2-bit next-turn logic. Tracks whose turn it is among up to MAX_PLAYERS players, advances on a rising edge of the main FSM's next-turn level signal, and supports reversible play direction and skipping eliminated players. Counts completed rounds and flags game over when one player remains. Sits between the main game FSM and the display/score blocks.

---
 rtl/turn_pkg.sv | 16 +
 rtl/rise_detect.sv | 19 +
 rtl/turn_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_turn_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared types and constants for the turn sequencer.
package turn_pkg;

  // Sequencer states: waiting for a game, idle turn, searching for next live player, finished
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    SEEK = 2'd2,
    OVER = 2'd3
  } state_t;

  // Play direction encodings as seen on the reverse input
  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is high while d is high and was low last cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  // Remember last cycle's level so a held-high input only produces one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: tracks the current player, steps on advance edges in either
// direction skipping eliminated players, counts rounds and detects the winner.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int  MAX_PLAYERS = 4,
  parameter int  ROUND_W     = 8,
  localparam int PW          = $clog2(MAX_PLAYERS),
  localparam int CW          = $clog2(MAX_PLAYERS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CW-1:0]          num_players,
  input  logic [PW-1:0]          first_player,
  input  logic                   advance,
  input  logic                   reverse,
  input  logic [MAX_PLAYERS-1:0] eliminate,
  output logic [PW-1:0]          turn,
  output logic                   turn_valid,
  output logic                   turn_changed,
  output logic [ROUND_W-1:0]     round_cnt,
  output logic                   round_inc,
  output logic                   game_over,
  output logic [PW-1:0]          winner
);

  state_t                 state, state_nxt;
  logic [MAX_PLAYERS-1:0] alive, alive_nxt, alive_new;
  logic [MAX_PLAYERS-1:0] start_mask, game_mask, elim_eff;
  logic [CW-1:0]          n_reg, n_nxt, alive_cnt;
  logic                   dir, dir_nxt;
  logic [PW-1:0]          cand, cand_nxt, turn_nxt, winner_nxt, last_idx;
  logic [PW-1:0]          step_src, step_to, n_last;
  logic                   step_dir, step_wrap;
  logic                   changed_nxt, rinc_nxt, start_ok, adv_edge;
  logic [ROUND_W-1:0]     round_nxt;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (advance),
    .rise  (adv_edge)
  );

  // Player masks, live-player count, survivor index and the filtered elimination
  always_comb begin
    start_mask = '0;
    game_mask  = '0;
    alive_cnt  = '0;
    last_idx   = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      start_mask[i] = (i < int'(num_players));
      game_mask[i]  = (i < int'(n_reg));
      alive_cnt     = alive_cnt + CW'(alive[i]);
    end
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      if (alive[i]) last_idx = PW'(i);
    end
    elim_eff  = eliminate & game_mask;
    alive_new = ((alive & ~elim_eff) == '0) ? alive : (alive & ~elim_eff);
    start_ok  = start && (int'(num_players) >= 2) && (int'(num_players) <= MAX_PLAYERS);
  end

  // One modulo step from the current turn (PLAY) or the pending candidate (SEEK)
  always_comb begin
    step_src  = (state == SEEK) ? cand : turn;
    step_dir  = (state == SEEK) ? dir : reverse;
    n_last    = PW'(n_reg - CW'(1));
    step_to   = step_src;
    step_wrap = 1'b0;
    if (step_dir == FWD) begin
      if (step_src == n_last) begin
        step_to   = '0;
        step_wrap = 1'b1;
      end else begin
        step_to = step_src + PW'(1);
      end
    end else begin
      if (step_src == '0) begin
        step_to   = n_last;
        step_wrap = 1'b1;
      end else begin
        step_to = step_src - PW'(1);
      end
    end
  end

  // Next-state and next-datapath decisions; a valid start overrides everything
  always_comb begin
    state_nxt   = state;
    alive_nxt   = alive_new;
    n_nxt       = n_reg;
    dir_nxt     = dir;
    cand_nxt    = cand;
    turn_nxt    = turn;
    changed_nxt = 1'b0;
    round_nxt   = round_cnt;
    rinc_nxt    = 1'b0;
    winner_nxt  = winner;
    if (start_ok) begin
      state_nxt  = PLAY;
      alive_nxt  = start_mask;
      n_nxt      = num_players;
      turn_nxt   = (CW'(first_player) < num_players) ? first_player : '0;
      round_nxt  = '0;
      winner_nxt = '0;
      dir_nxt    = FWD;
      cand_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          alive_nxt = alive;
        end
        PLAY: begin
          if (alive_cnt == CW'(1)) begin
            state_nxt  = OVER;
            winner_nxt = last_idx;
          end else if (adv_edge) begin
            state_nxt = SEEK;
            dir_nxt   = reverse;
            cand_nxt  = step_to;
            if (step_wrap) begin
              round_nxt = round_cnt + ROUND_W'(1);
              rinc_nxt  = 1'b1;
            end
          end
        end
        SEEK: begin
          if (alive_cnt == CW'(1)) begin
            state_nxt  = OVER;
            winner_nxt = last_idx;
          end else if (alive_new[cand]) begin
            state_nxt   = PLAY;
            turn_nxt    = cand;
            changed_nxt = 1'b1;
          end else begin
            cand_nxt = step_to;
            if (step_wrap) begin
              round_nxt = round_cnt + ROUND_W'(1);
              rinc_nxt  = 1'b1;
            end
          end
        end
        OVER: begin
          state_nxt = OVER;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers; reset aborts any search in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive        <= '0;
      n_reg        <= '0;
      dir          <= FWD;
      cand         <= '0;
      turn         <= '0;
      turn_changed <= 1'b0;
      round_cnt    <= '0;
      round_inc    <= 1'b0;
      winner       <= '0;
    end else begin
      alive        <= alive_nxt;
      n_reg        <= n_nxt;
      dir          <= dir_nxt;
      cand         <= cand_nxt;
      turn         <= turn_nxt;
      turn_changed <= changed_nxt;
      round_cnt    <= round_nxt;
      round_inc    <= rinc_nxt;
      winner       <= winner_nxt;
    end
  end

  assign turn_valid = (state != IDLE);
  assign game_over  = (state == OVER);

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer with MAX_PLAYERS=4.
module tb_turn_sequencer;

  localparam int MAXP = 4;
  localparam int RW   = 8;
  localparam int PW   = 2;
  localparam int CW   = 3;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   num_players;
  logic [PW-1:0]   first_player;
  logic            advance;
  logic            reverse;
  logic [MAXP-1:0] eliminate;
  logic [PW-1:0]   turn;
  logic            turn_valid;
  logic            turn_changed;
  logic [RW-1:0]   round_cnt;
  logic            round_inc;
  logic            game_over;
  logic [PW-1:0]   winner;

  typedef struct {
    int turn;
    int round;
  } exp_t;

  exp_t sb[$];
  int   check_cnt = 0;
  int   error_cnt = 0;
  int   pops      = 0;
  int   rinc_seen = 0;

  int   m_n     = 0;
  int   m_alive = 0;
  int   m_turn  = 0;
  int   m_round = 0;
  int   m_valid = 0;

  turn_sequencer #(
    .MAX_PLAYERS (MAXP),
    .ROUND_W     (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_players  (num_players),
    .first_player (first_player),
    .advance      (advance),
    .reverse      (reverse),
    .eliminate    (eliminate),
    .turn         (turn),
    .turn_valid   (turn_valid),
    .turn_changed (turn_changed),
    .round_cnt    (round_cnt),
    .round_inc    (round_inc),
    .game_over    (game_over),
    .winner       (winner)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int expv);
    check_cnt++;
    if (obs !== expv) begin
      error_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference next-player search over the bench's own alive mask
  function automatic void model_step(input int t, input bit rev,
                                     output int nt, output int k, output int wraps);
    int c;
    c = t; k = 0; wraps = 0; nt = t;
    for (int s = 0; s < MAXP; s++) begin
      if (!rev) begin
        if (c == m_n - 1) begin c = 0; wraps++; end
        else c++;
      end else begin
        if (c == 0) begin c = m_n - 1; wraps++; end
        else c--;
      end
      if (m_alive[c]) begin
        nt = c;
        break;
      end
      k++;
    end
  endfunction

  // Pop expected turn/round whenever the DUT reports a turn change; count round pulses
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (round_inc) rinc_seen++;
      if (turn_changed) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_turn_changed", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_turn", int'(turn), e.turn);
          checkOutput("sb_round", int'(round_cnt), e.round);
          pops++;
        end
      end
    end
  end

  task automatic doStart(input int n, input int fp);
    bit ok;
    ok = (n >= 2) && (n <= MAXP);
    start = 1'b1; num_players = CW'(n); first_player = PW'(fp);
    @(negedge clk); #1;
    start = 1'b0;
    if (ok) begin
      m_n = n; m_alive = (1 << n) - 1; m_turn = (fp < n) ? fp : 0;
      m_round = 0; m_valid = 1;
    end
    checkOutput("start_turn_valid", int'(turn_valid), m_valid);
    if (m_valid != 0) checkOutput("start_turn", int'(turn), m_turn);
    if (ok) checkOutput("start_round", int'(round_cnt), 0);
  endtask

  task automatic doEliminate(input int mask);
    int e;
    eliminate = MAXP'(mask);
    @(negedge clk); #1;
    eliminate = '0;
    e = mask & ((1 << m_n) - 1);
    if ((m_alive & ~e) != 0) m_alive = m_alive & ~e;
  endtask

  // One advance edge with the expectation pushed first; hold keeps advance high longer
  task automatic applyStimulus(input bit rev, input int hold);
    int nt, k, w, p0, r0, lat;
    model_step(m_turn, rev, nt, k, w);
    m_turn  = nt;
    m_round = (m_round + w) % (1 << RW);
    sb.push_back('{nt, m_round});
    p0 = pops; r0 = rinc_seen;
    reverse = rev; advance = 1'b1;
    lat = 0;
    while (pops == p0 && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    checkOutput("adv_latency", lat, 2 + k);
    checkOutput("round_inc_pulses", rinc_seen - r0, w);
    @(negedge clk); #1;
    checkOutput("changed_pulse_width", int'(turn_changed), 0);
    repeat (hold) begin
      @(negedge clk); #1;
    end
    advance = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    int p0, nt, k, w, lat;
    rst_n = 1'b1; start = 1'b0; num_players = '0; first_player = '0;
    advance = 1'b0; reverse = 1'b0; eliminate = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_turn", int'(turn), 0);
    checkOutput("reset_valid", int'(turn_valid), 0);
    checkOutput("reset_round", int'(round_cnt), 0);
    checkOutput("reset_game_over", int'(game_over), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    $display("[TB] three players forward from player 2");
    doStart(3, 2);
    applyStimulus(1'b0, 0);
    checkOutput("wrap_on_first_step", rinc_seen, 1);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b0, 0);
    checkOutput("t1_round_cnt", int'(round_cnt), 1);
    checkOutput("t1_turn", int'(turn), 2);

    $display("[TB] skip eliminated player 1");
    doStart(4, 0);
    doEliminate(4'b0010);
    applyStimulus(1'b0, 0);
    checkOutput("t2_turn", int'(turn), 2);

    $display("[TB] reverse direction with wrap");
    doStart(4, 1);
    p0 = rinc_seen;
    applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0);
    checkOutput("t3_turn", int'(turn), 3);
    checkOutput("t3_rinc", rinc_seen - p0, 1);
    checkOutput("t3_round", int'(round_cnt), 1);

    $display("[TB] double elimination ends the game");
    doStart(3, 0);
    doEliminate(4'b0101);
    checkOutput("over_not_yet", int'(game_over), 0);
    @(negedge clk); #1;
    checkOutput("over_flag", int'(game_over), 1);
    checkOutput("over_winner", int'(winner), 1);
    checkOutput("over_turn_kept", int'(turn), 0);
    checkOutput("over_valid", int'(turn_valid), 1);
    p0 = pops;
    advance = 1'b1;
    repeat (3) @(negedge clk);
    #1 advance = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("over_no_change", pops - p0, 0);
    checkOutput("over_turn_still", int'(turn), 0);
    doEliminate(4'b0010);
    @(negedge clk); #1;
    checkOutput("over_last_kept", int'(game_over), 1);
    checkOutput("over_winner_kept", int'(winner), 1);

    $display("[TB] held advance and edge during search");
    doStart(4, 0);
    applyStimulus(1'b0, 10);
    checkOutput("held_one_step", int'(turn), 1);
    doEliminate(4'b0100);
    model_step(m_turn, 1'b0, nt, k, w);
    m_turn = nt;
    sb.push_back('{nt, m_round});
    p0 = pops;
    reverse = 1'b0; advance = 1'b1;
    @(negedge clk); #1 advance = 1'b0;
    @(negedge clk); #1 advance = 1'b1;
    lat = 2;
    while (pops == p0 && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    checkOutput("seek_latency", lat, 2 + k);
    advance = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("seek_edge_dropped", pops - p0, 1);
    checkOutput("seek_turn", int'(turn), 3);

    $display("[TB] reset during search");
    doStart(4, 3);
    doEliminate(4'b0011);
    p0 = pops;
    reverse = 1'b0; advance = 1'b1;
    @(negedge clk); #1;
    checkOutput("seek_round_pre", int'(round_cnt), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_turn", int'(turn), 0);
    checkOutput("rst_valid", int'(turn_valid), 0);
    checkOutput("rst_round", int'(round_cnt), 0);
    checkOutput("rst_rinc", int'(round_inc), 0);
    checkOutput("rst_changed", int'(turn_changed), 0);
    m_valid = 0;
    advance = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_no_change", pops - p0, 0);
    doStart(5, 0);
    doStart(1, 0);
    doStart(2, 3);
    checkOutput("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
